// File: rtl/phys_reg_reclaim_buffer.sv
// phys_reg_reclaim_buffer
// Sits between ROB commit and phys_reg_free_list. Collects up to two freed
// previous-mapping tags per cycle, holds them in an in-order circular FIFO
// and drains one tag per cycle into the free list enqueue port through a
// registered output stage.
//
// Optional feature macro: RECLAIM_BYPASS_EN
//   When defined, the oldest accepted tag skips storage if the buffer is
//   empty and the drain is not stalled, so it reaches the output one cycle
//   earlier. Default build (undefined) always routes tags through storage.
//
// Tag 0 is the permanent r0 mapping and is never freed, so it is filtered
// at the input. Commits offered while commit_ready is low are dropped
// without any state change.

module phys_reg_reclaim_buffer #(
  parameter  int DEPTH = 8,
  parameter  int TAG_W = 7,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             commit_valid_0,
  input  logic [TAG_W-1:0] commit_phys_reg_tag_0,
  input  logic             commit_valid_1,
  input  logic [TAG_W-1:0] commit_phys_reg_tag_1,
  output logic             commit_ready,
  input  logic             free_list_stall,
  output logic             enqueue_valid,
  output logic [TAG_W-1:0] enqueue_phys_reg_tag,
  output logic [CW-1:0]    occupancy
);

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_enq_valid;
  logic [TAG_W-1:0] r_enq_tag;

  logic             w_ready;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_any_acc;
  logic [TAG_W-1:0] w_first_tag;
  logic             w_drain;
  logic             w_bypass;
  logic             w_wr0_en;
  logic [TAG_W-1:0] w_wr0_tag;
  logic             w_wr1_en;
  logic [TAG_W-1:0] w_wr1_tag;
  logic [1:0]       w_n_store;
  logic [PW-1:0]    w_tail_p1;

  // Ready needs room for a full pair, judged from the registered count only.
  assign w_ready = (r_count <= CW'(DEPTH - 2));

  // A slot is taken only when the buffer is ready and the tag is not r0.
  assign w_acc0    = w_ready & commit_valid_0 & (commit_phys_reg_tag_0 != '0);
  assign w_acc1    = w_ready & commit_valid_1 & (commit_phys_reg_tag_1 != '0);
  assign w_any_acc = w_acc0 | w_acc1;

  // Oldest accepted tag: slot 0 when it was taken, otherwise slot 1.
  assign w_first_tag = w_acc0 ? commit_phys_reg_tag_0 : commit_phys_reg_tag_1;

  // Storage drain happens whenever something is buffered and not stalled.
  assign w_drain = (r_count != '0) & ~free_list_stall;

`ifdef RECLAIM_BYPASS_EN
  // Empty, unstalled buffer: oldest accepted tag goes straight to the output.
  assign w_bypass = (r_count == '0) & ~free_list_stall & w_any_acc;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_tail_p1 = r_tail + PW'(1);

  // Decide which tags land in storage and at which tail offset.
  always_comb begin
    w_wr0_en  = 1'b0;
    w_wr0_tag = w_first_tag;
    w_wr1_en  = 1'b0;
    w_wr1_tag = commit_phys_reg_tag_1;
    if (w_bypass) begin
      // Oldest went to the output; only a second accepted tag is stored.
      w_wr0_en  = w_acc0 & w_acc1;
      w_wr0_tag = commit_phys_reg_tag_1;
    end else begin
      w_wr0_en  = w_any_acc;
      w_wr1_en  = w_acc0 & w_acc1;
    end
  end

  // Number of entries written this cycle (slot 1 write implies slot 0 write).
  assign w_n_store = w_wr1_en ? 2'd2 : (w_wr0_en ? 2'd1 : 2'd0);

  // Tag storage; contents are don't-care until covered by count, so no reset.
  always_ff @(posedge CLK) begin
    if (w_wr0_en) r_mem[r_tail]    <= w_wr0_tag;
    if (w_wr1_en) r_mem[w_tail_p1] <= w_wr1_tag;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PW'(w_n_store);
      r_head  <= r_head + PW'(w_drain);
      r_count <= r_count + CW'(w_n_store) - CW'(w_drain);
    end
  end

  // Registered enqueue port, refreshed every cycle from the drain decision.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_enq_valid <= 1'b0;
      r_enq_tag   <= '0;
    end else if (w_drain) begin
      r_enq_valid <= 1'b1;
      r_enq_tag   <= r_mem[r_head];
    end else if (w_bypass) begin
      r_enq_valid <= 1'b1;
      r_enq_tag   <= w_first_tag;
    end else begin
      r_enq_valid <= 1'b0;
      r_enq_tag   <= '0;
    end
  end

  assign commit_ready         = w_ready;
  assign enqueue_valid        = r_enq_valid;
  assign enqueue_phys_reg_tag = r_enq_tag;
  assign occupancy            = r_count;

endmodule

// File: tb/tb_phys_reg_reclaim_buffer.sv
// Directed bench for phys_reg_reclaim_buffer (default build, DEPTH=8).
// A hand-computed vector table covers the basic paths; multi-cycle corner
// cases use a small in-order queue model of the buffer contents.

module tb_phys_reg_reclaim_buffer;

  localparam int DEPTH = 8;
  localparam int TAG_W = 7;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             CLK;
  logic             nRST;
  logic             commit_valid_0;
  logic [TAG_W-1:0] commit_phys_reg_tag_0;
  logic             commit_valid_1;
  logic [TAG_W-1:0] commit_phys_reg_tag_1;
  logic             commit_ready;
  logic             free_list_stall;
  logic             enqueue_valid;
  logic [TAG_W-1:0] enqueue_phys_reg_tag;
  logic [CW-1:0]    occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [TAG_W-1:0] q[$];

  typedef struct {
    logic             v0;
    logic [TAG_W-1:0] t0;
    logic             v1;
    logic [TAG_W-1:0] t1;
    logic             stall;
    logic             e_valid;
    logic [TAG_W-1:0] e_tag;
    logic [CW-1:0]    e_occ;
    logic             e_ready;
  } vec_t;

  vec_t vecs[12];

  phys_reg_reclaim_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .CLK                   (CLK),
    .nRST                  (nRST),
    .commit_valid_0        (commit_valid_0),
    .commit_phys_reg_tag_0 (commit_phys_reg_tag_0),
    .commit_valid_1        (commit_valid_1),
    .commit_phys_reg_tag_1 (commit_phys_reg_tag_1),
    .commit_ready          (commit_ready),
    .free_list_stall       (free_list_stall),
    .enqueue_valid         (enqueue_valid),
    .enqueue_phys_reg_tag  (enqueue_phys_reg_tag),
    .occupancy             (occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [TAG_W-1:0] t0,
                       input logic v1, input logic [TAG_W-1:0] t1, input logic st);
    commit_valid_0        = v0;
    commit_phys_reg_tag_0 = t0;
    commit_valid_1        = v1;
    commit_phys_reg_tag_1 = t1;
    free_list_stall       = st;
  endtask

  // One clock with the queue model predicting the outputs after the edge.
  task automatic step(input string name, input logic v0, input logic [TAG_W-1:0] t0,
                      input logic v1, input logic [TAG_W-1:0] t1, input logic st);
    bit               rdy;
    bit               exp_v;
    logic [TAG_W-1:0] exp_t;
    rdy   = (q.size() <= DEPTH - 2);
    exp_v = (q.size() != 0) && !st;
    exp_t = '0;
    if (exp_v) exp_t = q.pop_front();
    if (rdy && v0 && t0 != '0) q.push_back(t0);
    if (rdy && v1 && t1 != '0) q.push_back(t1);
    drive(v0, t0, v1, t1, st);
    @(posedge CLK);
    #1;
    check({name, ".valid"}, 32'(enqueue_valid), 32'(exp_v));
    if (exp_v) check({name, ".tag"}, 32'(enqueue_phys_reg_tag), 32'(exp_t));
    check({name, ".occ"}, 32'(occupancy), 32'(q.size()));
    check({name, ".ready"}, 32'(commit_ready), 32'(q.size() <= DEPTH - 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [TAG_W-1:0] ta;
    int               tag_ctr;

    //           v0  t0     v1  t1     st  e_v  e_tag  occ ready
    vecs[0]  = '{0, 7'h00, 0, 7'h00, 0, 0, 7'h00, 4'd0, 1}; // idle
    vecs[1]  = '{1, 7'h11, 1, 7'h22, 0, 0, 7'h00, 4'd2, 1}; // dual commit
    vecs[2]  = '{0, 7'h00, 0, 7'h00, 0, 1, 7'h11, 4'd1, 1}; // N+2: slot 0 first
    vecs[3]  = '{0, 7'h00, 0, 7'h00, 0, 1, 7'h22, 4'd0, 1}; // then slot 1
    vecs[4]  = '{0, 7'h00, 0, 7'h00, 0, 0, 7'h00, 4'd0, 1}; // empty again
    vecs[5]  = '{1, 7'h00, 1, 7'h05, 0, 0, 7'h00, 4'd1, 1}; // zero filter
    vecs[6]  = '{0, 7'h00, 0, 7'h00, 0, 1, 7'h05, 4'd0, 1};
    vecs[7]  = '{0, 7'h00, 1, 7'h07, 0, 0, 7'h00, 4'd1, 1}; // slot 1 only
    vecs[8]  = '{1, 7'h08, 0, 7'h00, 0, 1, 7'h07, 4'd1, 1}; // commit + drain
    vecs[9]  = '{0, 7'h00, 0, 7'h00, 1, 0, 7'h00, 4'd1, 1}; // stalled
    vecs[10] = '{0, 7'h00, 0, 7'h00, 0, 1, 7'h08, 4'd0, 1};
    vecs[11] = '{1, 7'h00, 0, 7'h09, 0, 0, 7'h00, 4'd0, 1}; // nothing valid

    drive(0, '0, 0, '0, 0);
    nRST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset.valid", 32'(enqueue_valid), 32'd0);
    check("reset.occ",   32'(occupancy),     32'd0);
    check("reset.ready", 32'(commit_ready),  32'd1);
    nRST = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v0, vecs[i].t0, vecs[i].v1, vecs[i].t1, vecs[i].stall);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d.valid", i), 32'(enqueue_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid)
        check($sformatf("vec%0d.tag", i), 32'(enqueue_phys_reg_tag), 32'(vecs[i].e_tag));
      check($sformatf("vec%0d.occ", i), 32'(occupancy), 32'(vecs[i].e_occ));
      check($sformatf("vec%0d.ready", i), 32'(commit_ready), 32'(vecs[i].e_ready));
    end

    // Stall hold: three buffered tags held for four cycles, then back-to-back.
    step("hold_fill0", 1, 7'h31, 1, 7'h32, 1);
    step("hold_fill1", 1, 7'h33, 0, 7'h00, 1);
    for (int i = 0; i < 4; i++) step("hold_stall", 0, '0, 0, '0, 1);
    check("hold.occ3", 32'(occupancy), 32'd3);
    step("hold_rel0", 0, '0, 0, '0, 0);
    check("hold.first_tag", 32'(enqueue_phys_reg_tag), 32'h31);
    step("hold_rel1", 0, '0, 0, '0, 0);
    step("hold_rel2", 0, '0, 0, '0, 0);
    check("hold.last_tag", 32'(enqueue_phys_reg_tag), 32'h33);
    step("hold_idle", 0, '0, 0, '0, 0);

    // Full: fill to DEPTH under stall, then an ignored commit while draining.
    for (int i = 0; i < 4; i++) begin
      ta = 7'(64 + 2 * i);
      step("full_fill", 1, ta, 1, ta + 7'd1, 1);
    end
    check("full.occ", 32'(occupancy), 32'(DEPTH));
    check("full.ready", 32'(commit_ready), 32'd0);
    step("full_drop", 1, 7'h30, 0, '0, 0);
    check("full.drain_tag", 32'(enqueue_phys_reg_tag), 32'h40);
    check("full.occ_after", 32'(occupancy), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) step("full_drain", 0, '0, 0, '0, 0);

    // Fill to 7 under stall, then stream pairs for 3*DEPTH cycles with drain.
    tag_ctr = 0;
    step("wrap_single", 1, 7'h60, 0, '0, 1);
    for (int i = 0; i < DEPTH && q.size() <= DEPTH - 2; i++) begin
      ta = 7'((tag_ctr % 126) + 1);
      tag_ctr += 2;
      step("wrap_fill", 1, ta, 1, ta + 7'd1, 1);
    end
    check("wrap.occ7", 32'(occupancy), 32'd7);
    check("wrap.ready_low", 32'(commit_ready), 32'd0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      ta = 7'((tag_ctr % 126) + 1);
      tag_ctr += 2;
      step("wrap_stream", 1, ta, 1, ta + 7'd1, 0);
    end
    for (int i = 0; i < 2 * DEPTH; i++) step("wrap_drain", 0, '0, 0, '0, 0);

    // Reset mid-traffic with five tags buffered.
    step("rst_fill0", 1, 7'h51, 1, 7'h52, 1);
    step("rst_fill1", 1, 7'h53, 1, 7'h54, 1);
    step("rst_fill2", 1, 7'h56, 0, 7'h00, 1);
    check("rst.occ5", 32'(occupancy), 32'd5);
    drive(0, '0, 0, '0, 0);
    #2;
    nRST = 1'b1;
    #1;
    check("rst.async_valid", 32'(enqueue_valid), 32'd0);
    check("rst.async_occ",   32'(occupancy),     32'd0);
    check("rst.async_ready", 32'(commit_ready),  32'd1);
    q.delete();
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    step("post_rst0", 1, 7'h55, 0, '0, 0);
    step("post_rst1", 0, '0, 0, '0, 0);
    check("post_rst.tag", 32'(enqueue_phys_reg_tag), 32'h55);
    step("post_rst2", 0, '0, 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
